// File: rtl/button_input_filter.sv
// Two-channel push-button conditioner: 2-flop synchroniser, sampled saturating
// integrator with hysteresis, and a per-channel RELEASED/PRESSED/STUCK FSM.
module button_input_filter #(
   parameter int SAMPLE_DIV  = 32,
   parameter int INTEG_MAX   = 8,
   parameter int STUCK_TICKS = 10000
) (
   input  logic HCLK,
   input  logic HRESET,
   input  logic nMode_Pin,
   input  logic nTrip_Pin,
   output logic Mode,
   output logic Trip,
   output logic Mode_Stuck,
   output logic Trip_Stuck
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST   = CW'(SAMPLE_DIV - 1);
   localparam logic [3:0]    IMAX       = 4'(INTEG_MAX);
   localparam logic [15:0]   STUCK_LAST = 16'(STUCK_TICKS - 1);

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      STUCK    = 2'd2
   } state_t;

   logic [1:0]    pin;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [CW-1:0] presc;
   logic          sample_tick;
   logic [3:0]    integ     [2];
   logic [3:0]    integ_nxt [2];
   logic [1:0]    filt;
   logic [15:0]   hold      [2];
   logic [15:0]   hold_nxt  [2];
   state_t        state     [2];
   state_t        state_nxt [2];

   // Channel 0 is Mode, channel 1 is Trip.
   assign pin         = {nTrip_Pin, nMode_Pin};
   assign sample_tick = (presc == DIV_LAST);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
         presc <= '0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         presc <= sample_tick ? '0 : presc + CW'(1);
      end
   end

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         integ_nxt[c] = integ[c];
         if (sample_tick) begin
            if (sync2[c] && (integ[c] < IMAX))
               integ_nxt[c] = integ[c] + 4'd1;
            else if (!sync2[c] && (integ[c] != 4'd0))
               integ_nxt[c] = integ[c] - 4'd1;
         end
      end
   end

   // The filtered level moves on the same edge the integrator hits a bound.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int c = 0; c < 2; c++) integ[c] <= IMAX;
         filt <= 2'b11;
      end else begin
         for (int c = 0; c < 2; c++) begin
            integ[c] <= integ_nxt[c];
            if (integ_nxt[c] == 4'd0)
               filt[c] <= 1'b0;
            else if (integ_nxt[c] == IMAX)
               filt[c] <= 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int c = 0; c < 2; c++) begin
            state[c] <= RELEASED;
            hold[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            state[c] <= state_nxt[c];
            hold[c]  <= hold_nxt[c];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         state_nxt[c] = state[c];
         hold_nxt[c]  = hold[c];
         case (state[c])
            RELEASED: begin
               hold_nxt[c] = '0;
               if (!filt[c]) state_nxt[c] = PRESSED;
            end
            PRESSED: begin
               if (filt[c])
                  state_nxt[c] = RELEASED;
               else if (sample_tick) begin
                  if (hold[c] == STUCK_LAST)
                     state_nxt[c] = STUCK;
                  else
                     hold_nxt[c] = hold[c] + 16'd1;
               end
            end
            STUCK: begin
               // Counter is frozen here; only a release leaves this state.
               if (filt[c]) state_nxt[c] = RELEASED;
            end
            default: state_nxt[c] = RELEASED;
         endcase
      end
   end

   // A stuck button reads as released so downstream timers recover.
   assign Mode       = (state[0] != PRESSED);
   assign Trip       = (state[1] != PRESSED);
   assign Mode_Stuck = (state[0] == STUCK);
   assign Trip_Stuck = (state[1] == STUCK);

endmodule

// File: tb/tb_button_input_filter.sv
// Bench for button_input_filter: three parameterisations driven by shared pins,
// checked every cycle against a tick-counting reference model plus directed checks.
module tb_button_input_filter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic nmode = 1'b1;
   logic ntrip = 1'b1;
   logic [2:0] mode_o, trip_o, mstk_o, tstk_o;

   int total = 0;
   int bad   = 0;

   logic t0_low = 1'b0;
   logic t2_low = 1'b0;

   always #5 clk = ~clk;

   button_input_filter u0 (
      .HCLK(clk), .HRESET(rst), .nMode_Pin(nmode), .nTrip_Pin(ntrip),
      .Mode(mode_o[0]), .Trip(trip_o[0]), .Mode_Stuck(mstk_o[0]), .Trip_Stuck(tstk_o[0])
   );

   button_input_filter #(.STUCK_TICKS(16)) u1 (
      .HCLK(clk), .HRESET(rst), .nMode_Pin(nmode), .nTrip_Pin(ntrip),
      .Mode(mode_o[1]), .Trip(trip_o[1]), .Mode_Stuck(mstk_o[1]), .Trip_Stuck(tstk_o[1])
   );

   button_input_filter #(.SAMPLE_DIV(2), .INTEG_MAX(2)) u2 (
      .HCLK(clk), .HRESET(rst), .nMode_Pin(nmode), .nTrip_Pin(ntrip),
      .Mode(mode_o[2]), .Trip(trip_o[2]), .Mode_Stuck(mstk_o[2]), .Trip_Stuck(tstk_o[2])
   );

   function automatic int sd_of(input int i);
      return (i == 2) ? 2 : 32;
   endfunction

   function automatic int im_of(input int i);
      return (i == 2) ? 2 : 8;
   endfunction

   function automatic int st_of(input int i);
      return (i == 1) ? 16 : 10000;
   endfunction

   function automatic logic get_out(input int i, input int sig);
      case (sig)
         0:       return mode_o[i];
         1:       return trip_o[i];
         2:       return mstk_o[i];
         default: return tstk_o[i];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Reference model: pins delayed two edges, a clamped up/down count per sample
   // tick, and an output that goes low once the filtered level is low and returns
   // high (with stuck flagged) after STUCK_TICKS further ticks.
   int   integ_m   [3][2];
   logic filt_m    [3][2];
   logic h_a       [3][2];
   logic h_b       [3][2];
   logic pressed_m [3][2];
   int   ticks_m   [3][2];
   logic exp_lvl   [3][2];
   logic exp_stk   [3][2];
   int   cyc_m;

   task automatic model_reset();
      cyc_m = 0;
      for (int i = 0; i < 3; i++)
         for (int c = 0; c < 2; c++) begin
            integ_m[i][c]   = im_of(i);
            filt_m[i][c]    = 1'b1;
            h_a[i][c]       = 1'b1;
            h_b[i][c]       = 1'b1;
            pressed_m[i][c] = 1'b0;
            ticks_m[i][c]   = 0;
            exp_lvl[i][c]   = 1'b1;
            exp_stk[i][c]   = 1'b0;
         end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 3; i++) begin
            logic tick;
            tick = ((cyc_m % sd_of(i)) == sd_of(i) - 1);
            for (int c = 0; c < 2; c++) begin
               logic p, s;
               p = (c == 0) ? nmode : ntrip;
               if (filt_m[i][c]) begin
                  pressed_m[i][c] = 1'b0;
                  ticks_m[i][c]   = 0;
               end else if (!pressed_m[i][c]) begin
                  pressed_m[i][c] = 1'b1;
                  ticks_m[i][c]   = 0;
               end else if (tick && ticks_m[i][c] < st_of(i)) begin
                  ticks_m[i][c]++;
               end
               exp_lvl[i][c] = !(pressed_m[i][c] && ticks_m[i][c] < st_of(i));
               exp_stk[i][c] = pressed_m[i][c] && ticks_m[i][c] >= st_of(i);
               s = h_a[i][c];
               h_a[i][c] = h_b[i][c];
               h_b[i][c] = p;
               if (tick) begin
                  if (s && integ_m[i][c] < im_of(i)) integ_m[i][c]++;
                  else if (!s && integ_m[i][c] > 0) integ_m[i][c]--;
               end
               if (integ_m[i][c] == 0) filt_m[i][c] = 1'b0;
               else if (integ_m[i][c] == im_of(i)) filt_m[i][c] = 1'b1;
            end
         end
         cyc_m++;
      end
   end

   initial model_reset();

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d_mode", i),  mode_o[i], exp_lvl[i][0]);
         chk($sformatf("u%0d_trip", i),  trip_o[i], exp_lvl[i][1]);
         chk($sformatf("u%0d_mstk", i),  mstk_o[i], exp_stk[i][0]);
         chk($sformatf("u%0d_tstk", i),  tstk_o[i], exp_stk[i][1]);
      end
      if (trip_o[0] !== 1'b1) t0_low = 1'b1;
      if (trip_o[2] !== 1'b1) t2_low = 1'b1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges counted from the first edge after the call until the output reaches val.
   task automatic wait_for(input int i, input int sig, input logic val, input int bound,
                           output int n);
      n = -1;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk);
         #1;
         if (get_out(i, sig) === val) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic wait_both(input logic val, input int bound, output int nm, output int nt);
      nm = -1;
      nt = -1;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk);
         #1;
         if (nm < 0 && mode_o[0] === val) nm = k;
         if (nt < 0 && trip_o[0] === val) nt = k;
         if (nm >= 0 && nt >= 0) break;
      end
   endtask

   function automatic logic in_rng(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

   initial begin
      int n, d, nm, nt;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mode", mode_o, 3'b111);
      chk("rst_trip", trip_o, 3'b111);
      chk("rst_mstk", mstk_o, 3'b000);
      chk("rst_tstk", tstk_o, 3'b000);

      // Clean press and release
      step(5);
      nmode = 1'b0;
      wait_for(0, 0, 1'b0, 400, n);
      chk($sformatf("press_lat=%0d", n), in_rng(n, 228, 259), 1'b1);
      chk("press_trip_idle", trip_o[0], 1'b1);
      chk("press_no_stuck", mstk_o[0], 1'b0);
      step(1000 - n);
      nmode = 1'b1;
      wait_for(0, 0, 1'b1, 400, n);
      chk($sformatf("release_lat=%0d", n), in_rng(n, 228, 259), 1'b1);
      step(300);

      // Bounce on Trip
      t0_low = 1'b0;
      for (int r = 0; r < 5; r++) begin
         ntrip = 1'b0;
         step(96);
         ntrip = 1'b1;
         step(64);
      end
      step(400);
      chk("glitch_trip_low_seen", t0_low, 1'b0);

      // Stuck on the STUCK_TICKS=16 instance
      nmode = 1'b0;
      wait_for(1, 0, 1'b0, 400, n);
      wait_for(1, 2, 1'b1, 700, d);
      chk($sformatf("stuck_low_len=%0d", d), in_rng(d, 511, 512), 1'b1);
      chk("stuck_mode_high", mode_o[1], 1'b1);
      nmode = 1'b1;
      wait_for(1, 2, 1'b0, 400, n);
      chk($sformatf("stuck_clear_lat=%0d", n), in_rng(n, 228, 259), 1'b1);
      chk("stuck_clear_mode", mode_o[1], 1'b1);
      step(300);

      // Simultaneous press and release
      nmode = 1'b0;
      ntrip = 1'b0;
      wait_both(1'b0, 400, nm, nt);
      chk($sformatf("simul_fall_lat=%0d", nm), in_rng(nm, 228, 259), 1'b1);
      chk("simul_fall_same", nt, nm);
      step(100);
      nmode = 1'b1;
      ntrip = 1'b1;
      wait_both(1'b1, 400, nm, nt);
      chk($sformatf("simul_rise_lat=%0d", nm), in_rng(nm, 228, 259), 1'b1);
      chk("simul_rise_same", nt, nm);
      step(300);

      // Reset while pressed
      nmode = 1'b0;
      wait_for(0, 0, 1'b0, 400, n);
      chk("pre_reset_mode", mode_o[0], 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_mode", mode_o, 3'b111);
      chk("async_rst_mstk", mstk_o, 3'b000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_for(0, 0, 1'b0, 400, n);
      chk($sformatf("post_reset_lat=%0d", n), in_rng(n, 228, 259), 1'b1);
      nmode = 1'b1;
      step(300);

      // Fast-sampling instance: latency and a sub-threshold pulse
      nmode = 1'b0;
      wait_for(2, 0, 1'b0, 20, n);
      chk($sformatf("fast_lat=%0d", n), in_rng(n, 6, 7), 1'b1);
      step(50);
      nmode = 1'b1;
      step(50);
      t2_low = 1'b0;
      ntrip = 1'b0;
      step(2);
      ntrip = 1'b1;
      step(20);
      chk("fast_pulse_trip_low_seen", t2_low, 1'b0);
      step(300);

      // Random pin activity against the model
      for (int r = 0; r < 200; r++) begin
         nmode = 1'($urandom_range(0, 1));
         ntrip = 1'($urandom_range(0, 1));
         step($urandom_range(1, 300));
      end
      step(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
